// File: rtl/commanding_officer_unlock.sv
// Button-combination unlock: synchronises and debounces four active-low buttons,
// then tracks entry of the fixed 8-symbol code and raises a sticky unlock flag.
module commanding_officer_unlock #(
    parameter int CLK_FREQ        = 48_000_000,
    parameter int DEBOUNCE_CYCLES = CLK_FREQ / 100,
    parameter int TIMEOUT_CYCLES  = CLK_FREQ * 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_n,
    output logic       got_commanding_officer,
    output logic [3:0] progress
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTRY    = 2'd1,
        UNLOCKED = 2'd2
    } state_t;

    // Expected button (active-high one-hot: UP, DOWN, LEFT, RIGHT) at each code position
    function automatic logic [3:0] code_sym(input logic [2:0] idx);
        logic [3:0] sym;
        case (idx)
            3'd0, 3'd1: sym = 4'b0001;
            3'd2, 3'd3: sym = 4'b0010;
            3'd4, 3'd6: sym = 4'b0100;
            3'd5, 3'd7: sym = 4'b1000;
            default:    sym = 4'b0000;
        endcase
        return sym;
    endfunction

    logic [3:0]      sync1_r;
    logic [3:0]      sync2_r;
    logic [3:0]      deb_r;
    logic [3:0]      deb_prev_r;
    logic [DB_W-1:0] deb_cnt_r [4];
    logic [TO_W-1:0] tmo_r;
    logic [3:0]      progress_r;
    logic            unlocked_r;
    state_t          state_r;

    logic [3:0]      press_s;
    logic [3:0]      exp_sym_s;
    logic            single_s;
    logic            multi_s;

    // Two-flop synchroniser; released (high) is the reset level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 4'b1111;
            sync2_r <= 4'b1111;
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
        end
    end

    // Per-button debouncer: level flips after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r      <= 4'b1111;
            deb_prev_r <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            deb_prev_r <= deb_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (deb_cnt_r[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb_r[i]     <= sync2_r[i];
                        deb_cnt_r[i] <= {DB_W{1'b0}};
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + {{(DB_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    deb_cnt_r[i] <= {DB_W{1'b0}};
                end
            end
        end
    end

    // Press pulses and single/multiple press classification
    always_comb begin
        press_s   = deb_prev_r & ~deb_r;
        exp_sym_s = code_sym(progress_r[2:0]);
        if (press_s == 4'b0000) begin
            single_s = 1'b0;
            multi_s  = 1'b0;
        end else if ((press_s & (press_s - 4'b0001)) == 4'b0000) begin
            single_s = 1'b1;
            multi_s  = 1'b0;
        end else begin
            single_s = 1'b0;
            multi_s  = 1'b1;
        end
    end

    // Code-entry FSM with idle timeout; outputs are held in flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            progress_r <= 4'd0;
            unlocked_r <= 1'b0;
            tmo_r      <= {TO_W{1'b0}};
        end else begin
            case (state_r)
                IDLE, ENTRY: begin
                    if (multi_s) begin
                        state_r    <= IDLE;
                        progress_r <= 4'd0;
                        tmo_r      <= {TO_W{1'b0}};
                    end else if (single_s) begin
                        tmo_r <= {TO_W{1'b0}};
                        if (press_s == exp_sym_s) begin
                            if (progress_r == 4'd7) begin
                                state_r    <= UNLOCKED;
                                progress_r <= 4'd8;
                                unlocked_r <= 1'b1;
                            end else begin
                                state_r    <= ENTRY;
                                progress_r <= progress_r + 4'd1;
                            end
                        end else if (press_s == 4'b0001) begin
                            // A stray UP still counts as a code start; after UP,UP it keeps both
                            state_r    <= ENTRY;
                            progress_r <= (progress_r == 4'd2) ? 4'd2 : 4'd1;
                        end else begin
                            state_r    <= IDLE;
                            progress_r <= 4'd0;
                        end
                    end else if (state_r == ENTRY) begin
                        if (tmo_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            state_r    <= IDLE;
                            progress_r <= 4'd0;
                            tmo_r      <= {TO_W{1'b0}};
                        end else begin
                            tmo_r <= tmo_r + {{(TO_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        tmo_r <= {TO_W{1'b0}};
                    end
                end
                UNLOCKED: begin
                    progress_r <= 4'd8;
                    unlocked_r <= 1'b1;
                    tmo_r      <= {TO_W{1'b0}};
                end
                default: begin
                    state_r    <= IDLE;
                    progress_r <= 4'd0;
                    unlocked_r <= 1'b0;
                    tmo_r      <= {TO_W{1'b0}};
                end
            endcase
        end
    end

    assign got_commanding_officer = unlocked_r;
    assign progress               = progress_r;

endmodule
